// File: rtl/ccd_readout_sequencer.sv
// rtl/ccd_readout_sequencer.sv - CCD pixel readout sequencer with ADC handshake, sample FIFO and Wishbone registers
//
// Purpose: follows the clock-waveform generator's phi_p/phi_r pads, settles after
// each reset-gate release, runs one ADC conversion per pixel, and queues
// {pixel index, sample} words for the management core.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   wbs_stb_i/cyc_i/we_i      Wishbone slave controls
//   wbs_sel_i                 byte selects (ignored, word accesses only)
//   wbs_adr_i, wbs_dat_i      address / write data
//   wbs_ack_o, wbs_dat_o      acknowledge / read data
//   phi_p_i, phi_r_i          generator pads, asynchronous to wb_clk_i
//   adc_start_o               one-cycle conversion request
//   adc_done_i, adc_data_i    conversion complete pulse and result
//   irq_o                     level interrupt
//
// Registers (word offsets from BASE_ADDRESS):
//   +0x0 CTRL   [0] enable [1] irq_en [2] flush (write-1 pulse, reads 0)
//   +0x4 STATUS [0] empty [1] full [2] overflow [3] line_done [4] abort [5] timeout [15:8] level
//   +0x8 DATA   [11:0] sample [23:12] pixel index; reading pops
//   +0xC PIXCNT [11:0] pixels converted in the current line
//
// Build option: READOUT_ADC_TIMEOUT_EN adds a CONVERT watchdog (ADC_TIMEOUT cycles).

module ccd_readout_sequencer #(
  parameter logic [31:0] BASE_ADDRESS    = 32'h3000_0020,
  parameter int          PIXELS_PER_LINE = 2052,
  parameter int          SETTLE_CYCLES   = 4,
  parameter int          FIFO_DEPTH      = 16,
  parameter int          ADC_WIDTH       = 12,
  parameter int          ADC_TIMEOUT     = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  input  logic                 phi_p_i,
  input  logic                 phi_r_i,
  output logic                 adc_start_o,
  input  logic                 adc_done_i,
  input  logic [ADC_WIDTH-1:0] adc_data_i,
  output logic                 irq_o
);

  localparam int          AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW          = AW + 1;
  localparam logic [11:0] LAST_PIX    = 12'(PIXELS_PER_LINE - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_PIX = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_CONVERT  = 3'd3,
    ST_STORE    = 3'd4
  } state_t;

  // Pad synchronisers: [0],[1] metastability stages, [2] history for edges.
  logic [2:0] phi_p_sync_q, phi_p_sync_d;
  logic [2:0] phi_r_sync_q, phi_r_sync_d;
  logic       phi_p_fall, phi_p_rise, phi_r_fall;

  state_t      state_q, state_d;
  logic [7:0]  settle_cnt_q, settle_cnt_d;
  logic        conv_started_q, conv_started_d;
  logic [11:0] sample_q, sample_d;
  logic [11:0] pix_cnt_q, pix_cnt_d;

  logic enable_q, enable_d;
  logic irq_en_q, irq_en_d;
  logic overflow_q, overflow_d;
  logic line_done_q, line_done_d;
  logic abort_q, abort_d;
  logic timeout_flag;

`ifdef READOUT_ADC_TIMEOUT_EN
  localparam logic [7:0] WDOG_LAST = 8'(ADC_TIMEOUT - 1);
  logic [7:0] wdog_q, wdog_d;
  logic       timeout_q, timeout_d;
`endif

  logic [23:0]   fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty, full;
  logic [23:0]   fifo_head;

  logic        ack_q, ack_d;
  logic        we_q, we_d;
  logic [1:0]  off_q, off_d;
  logic [5:0]  wdat_q, wdat_d;
  logic [31:0] adr_off;
  logic        in_win, wb_req;
  logic        wr_ctrl, wr_status, rd_data;
  logic [31:0] rdata;

  logic push_req, push_fire, pop_fire, flush, overflow_set;
  logic line_done_set, abort_set, timeout_set;
  logic adc_start;

  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i, wbs_dat_i[31:6], adr_off[1:0]};

  // ---------------- synchronisers and edge detect ----------------
  always_comb begin
    phi_p_sync_d = {phi_p_sync_q[1:0], phi_p_i};
    phi_r_sync_d = {phi_r_sync_q[1:0], phi_r_i};
  end

  assign phi_p_fall = phi_p_sync_q[2] & ~phi_p_sync_q[1];
  assign phi_p_rise = ~phi_p_sync_q[2] & phi_p_sync_q[1];
  assign phi_r_fall = phi_r_sync_q[2] & ~phi_r_sync_q[1];

  // ---------------- Wishbone front end ----------------
  // One transfer is accepted per ack; ack_q blocks back-to-back acks so there
  // is always an idle cycle between them. Side effects happen on the ack cycle.
  assign adr_off = wbs_adr_i - BASE_ADDRESS;
  assign in_win  = (adr_off < 32'd16);
  assign wb_req  = wbs_stb_i & wbs_cyc_i & in_win & ~ack_q;

  always_comb begin
    ack_d  = wb_req;
    we_d   = we_q;
    off_d  = off_q;
    wdat_d = wdat_q;
    if (wb_req) begin
      we_d   = wbs_we_i;
      off_d  = adr_off[3:2];
      wdat_d = wbs_dat_i[5:0];
    end
  end

  assign wr_ctrl   = ack_q & we_q & (off_q == 2'd0);
  assign wr_status = ack_q & we_q & (off_q == 2'd1);
  assign rd_data   = ack_q & ~we_q & (off_q == 2'd2);

  // ---------------- sequencer FSM ----------------
  always_comb begin
    state_d        = state_q;
    settle_cnt_d   = settle_cnt_q;
    conv_started_d = 1'b0;
    sample_d       = sample_q;
    pix_cnt_d      = pix_cnt_q;
    push_req       = 1'b0;
    line_done_set  = 1'b0;
    abort_set      = 1'b0;
    timeout_set    = 1'b0;
    adc_start      = 1'b0;
`ifdef READOUT_ADC_TIMEOUT_EN
    wdog_d         = 8'd0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (enable_q && phi_p_fall) begin
          pix_cnt_d = 12'd0;
          state_d   = ST_WAIT_PIX;
        end
      end
      ST_WAIT_PIX: begin
        if (phi_r_fall) begin
          settle_cnt_d = 8'd0;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // The entry cycle is the edge-detection cycle; the following
        // SETTLE_CYCLES cycles are the settle time proper.
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = ST_CONVERT;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      ST_CONVERT: begin
        adc_start      = ~conv_started_q;
        conv_started_d = 1'b1;
        if (adc_done_i) begin
          sample_d = 12'(adc_data_i);
          state_d  = ST_STORE;
        end
`ifdef READOUT_ADC_TIMEOUT_EN
        else if (wdog_q == WDOG_LAST) begin
          timeout_set = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
`endif
      end
      ST_STORE: begin
        push_req  = 1'b1;
        pix_cnt_d = pix_cnt_q + 12'd1;
        if (pix_cnt_q == LAST_PIX) begin
          line_done_set = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          state_d = ST_WAIT_PIX;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides the next state only; a STORE in this cycle still pushes.
    if ((state_q != ST_IDLE) && phi_p_rise) begin
      abort_set = 1'b1;
      state_d   = ST_IDLE;
    end
    if (!enable_q) begin
      state_d = ST_IDLE;
    end
  end

  assign adc_start_o = adc_start;

  // ---------------- sample FIFO ----------------
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign fifo_head = fifo_mem_q[rd_ptr_q];

  always_comb begin
    flush        = wr_ctrl & wdat_q[2];
    pop_fire     = rd_data & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_fire    = push_req & ~flush & (~full | pop_fire);
    overflow_set = push_req & ~flush & full & ~pop_fire;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_fire) begin
      fifo_mem_q[wr_ptr_q] <= {pix_cnt_q, sample_q};
    end
  end

  // ---------------- control / status registers ----------------
  always_comb begin
    enable_d    = wr_ctrl ? wdat_q[0] : enable_q;
    irq_en_d    = wr_ctrl ? wdat_q[1] : irq_en_q;
    // Set beats W1C when both land in the same cycle.
    overflow_d  = overflow_set  | (overflow_q  & ~(wr_status & wdat_q[2]));
    line_done_d = line_done_set | (line_done_q & ~(wr_status & wdat_q[3]));
    abort_d     = abort_set     | (abort_q     & ~(wr_status & wdat_q[4]));
`ifdef READOUT_ADC_TIMEOUT_EN
    timeout_d   = timeout_set   | (timeout_q   & ~(wr_status & wdat_q[5]));
`endif
  end

`ifdef READOUT_ADC_TIMEOUT_EN
  assign timeout_flag = timeout_q;
`else
  assign timeout_flag = 1'b0 & timeout_set;
`endif

  always_comb begin
    rdata = 32'd0;
    case (off_q)
      2'd0:    rdata = {30'd0, irq_en_q, enable_q};
      2'd1:    rdata = {16'd0, 8'(count_q), 2'b00, timeout_flag, abort_q,
                        line_done_q, overflow_q, full, empty};
      2'd2:    rdata = empty ? 32'd0 : {8'd0, fifo_head};
      default: rdata = {20'd0, pix_cnt_q};
    endcase
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = ack_q ? rdata : 32'd0;
  assign irq_o     = irq_en_q & (line_done_q | overflow_q | abort_q | timeout_flag | ~empty);

  // ---------------- state registers ----------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      phi_p_sync_q   <= 3'd0;
      phi_r_sync_q   <= 3'd0;
      state_q        <= ST_IDLE;
      settle_cnt_q   <= 8'd0;
      conv_started_q <= 1'b0;
      sample_q       <= 12'd0;
      pix_cnt_q      <= 12'd0;
      enable_q       <= 1'b0;
      irq_en_q       <= 1'b0;
      overflow_q     <= 1'b0;
      line_done_q    <= 1'b0;
      abort_q        <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      ack_q          <= 1'b0;
      we_q           <= 1'b0;
      off_q          <= 2'd0;
      wdat_q         <= 6'd0;
`ifdef READOUT_ADC_TIMEOUT_EN
      wdog_q         <= 8'd0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      phi_p_sync_q   <= phi_p_sync_d;
      phi_r_sync_q   <= phi_r_sync_d;
      state_q        <= state_d;
      settle_cnt_q   <= settle_cnt_d;
      conv_started_q <= conv_started_d;
      sample_q       <= sample_d;
      pix_cnt_q      <= pix_cnt_d;
      enable_q       <= enable_d;
      irq_en_q       <= irq_en_d;
      overflow_q     <= overflow_d;
      line_done_q    <= line_done_d;
      abort_q        <= abort_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      ack_q          <= ack_d;
      we_q           <= we_d;
      off_q          <= off_d;
      wdat_q         <= wdat_d;
`ifdef READOUT_ADC_TIMEOUT_EN
      wdog_q         <= wdog_d;
      timeout_q      <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_ccd_readout_sequencer.sv
// tb/tb_ccd_readout_sequencer.sv - self-checking bench for ccd_readout_sequencer

module tb_ccd_readout_sequencer;

  localparam logic [31:0] BASE   = 32'h3000_0020;
  localparam logic [31:0] CTRL   = BASE;
  localparam logic [31:0] STATUS = BASE + 32'h4;
  localparam logic [31:0] DATA   = BASE + 32'h8;
  localparam logic [31:0] PIXCNT = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = 32'd0, dat_w = 32'd0;
  logic        ack;
  logic [31:0] dat_r;
  logic        phi_p = 1'b1, phi_r = 1'b1;
  logic        adc_start;
  logic        adc_done = 1'b0;
  logic [11:0] adc_data = 12'd0;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic        exp_ack;
    logic [31:0] exp_rdata;
  } wb_vec_t;

  wb_vec_t vecs[12];

  ccd_readout_sequencer #(
    .BASE_ADDRESS(BASE), .PIXELS_PER_LINE(4), .SETTLE_CYCLES(4),
    .FIFO_DEPTH(2), .ADC_WIDTH(12), .ADC_TIMEOUT(20)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
    .phi_p_i(phi_p), .phi_r_i(phi_r),
    .adc_start_o(adc_start), .adc_done_i(adc_done), .adc_data_i(adc_data),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         output logic [31:0] rd, output logic got);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_w = d;
    got = 1'b0; rd = 32'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (ack) begin
        got = 1'b1;
        rd  = dat_r;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    tick();
  endtask

  task automatic wb_rd(input logic [31:0] a, input string name, input logic [31:0] exp);
    logic [31:0] rd;
    logic got;
    wb_xfer(a, 1'b0, 32'd0, rd, got);
    check({name, "_ack"}, {31'd0, got}, 32'd1);
    check(name, rd, exp);
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic got;
    wb_xfer(a, 1'b1, d, rd, got);
    check("write_ack", {31'd0, got}, 32'd1);
  endtask

  task automatic sb_read(input string name);
    logic [31:0] exp;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'd0;
    wb_rd(DATA, name, exp);
  endtask

  task automatic line_start();
    phi_p = 1'b0;
    repeat (4) tick();
  endtask

  // mode 0: plain pixel; 1: DATA read whose ack lands on the STORE cycle;
  // 2: CTRL flush write whose ack lands on the STORE cycle.
  task automatic do_pixel(input logic [11:0] val, input int mode, input logic chk_lat);
    int first;
    int nstart;
    logic [31:0] exp;
    first = 0;
    nstart = 0;
    phi_r = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (adc_start) begin
        nstart++;
        if (first == 0) first = k;
      end
      if (first != 0 && k == first + 3) begin
        adc_done = 1'b1;
        adc_data = val;
        if (mode == 1) begin
          stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = DATA;
        end else if (mode == 2) begin
          stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = CTRL; dat_w = 32'h7;
        end
      end
      if (first != 0 && k == first + 4) begin
        adc_done = 1'b0;
        adc_data = 12'd0;
        if (mode == 1) begin
          check("pop_push_ack", {31'd0, ack}, 32'd1);
          exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'd0;
          check("pop_push_data", dat_r, exp);
        end else if (mode == 2) begin
          check("flush_push_ack", {31'd0, ack}, 32'd1);
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        break;
      end
    end
    check("adc_start_seen", {31'd0, first != 0}, 32'd1);
    check("adc_start_single", nstart, 1);
    if (chk_lat) check("start_latency", first, 8);
    phi_r = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    int nstart;
    logic [31:0] rd;
    logic got;

    vecs[0]  = '{CTRL,   1'b0, 32'd0, 1'b1, 32'h0};
    vecs[1]  = '{STATUS, 1'b0, 32'd0, 1'b1, 32'h1};
    vecs[2]  = '{DATA,   1'b0, 32'd0, 1'b1, 32'h0};
    vecs[3]  = '{PIXCNT, 1'b0, 32'd0, 1'b1, 32'h0};
    vecs[4]  = '{BASE + 32'h10, 1'b0, 32'd0, 1'b0, 32'h0};
    vecs[5]  = '{BASE - 32'h4,  1'b0, 32'd0, 1'b0, 32'h0};
    vecs[6]  = '{CTRL,   1'b1, 32'h7, 1'b1, 32'h0};
    vecs[7]  = '{CTRL,   1'b0, 32'd0, 1'b1, 32'h3};
    vecs[8]  = '{STATUS, 1'b0, 32'd0, 1'b1, 32'h1};
    vecs[9]  = '{CTRL,   1'b1, 32'h0, 1'b1, 32'h0};
    vecs[10] = '{CTRL,   1'b0, 32'd0, 1'b1, 32'h0};
    vecs[11] = '{BASE + 32'h10, 1'b1, 32'h3, 1'b0, 32'h0};

    repeat (3) tick();
    check("rst_adc_start", {31'd0, adc_start}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      wb_xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, rd, got);
      check($sformatf("vec%0d_ack", i), {31'd0, got}, {31'd0, vecs[i].exp_ack});
      if (!vecs[i].wr && vecs[i].exp_ack) check($sformatf("vec%0d_data", i), rd, vecs[i].exp_rdata);
    end

    // Full line, reading each sample as it lands.
    wb_wr(CTRL, 32'h3);
    check("irq_idle_empty", {31'd0, irq}, 32'd0);
    line_start();
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back({8'd0, 12'(i), 12'h100 + 12'(i)});
      do_pixel(12'h100 + 12'(i), 0, i == 0);
      if (i == 0) check("irq_not_empty", {31'd0, irq}, 32'd1);
      sb_read($sformatf("line_px%0d", i));
    end
    wb_rd(STATUS, "line_done_status", 32'h9);
    check("irq_line_done", {31'd0, irq}, 32'd1);
    wb_rd(PIXCNT, "pixcnt_full", 32'd4);
    phi_p = 1'b1;
    repeat (4) tick();
    wb_wr(STATUS, 32'h8);
    wb_rd(STATUS, "line_done_clear", 32'h1);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // Overflow: depth 2, four pixels, no reads.
    line_start();
    for (int i = 0; i < 4; i++) begin
      if (i < 2) sb_q.push_back({8'd0, 12'(i), 12'h200 + 12'(i)});
      do_pixel(12'h200 + 12'(i), 0, 1'b0);
    end
    wb_rd(STATUS, "overflow_status", 32'h20E);
    wb_rd(PIXCNT, "pixcnt_overflow", 32'd4);
    sb_read("overflow_kept0");
    sb_read("overflow_kept1");
    wb_wr(STATUS, 32'h4);
    wb_rd(STATUS, "overflow_clear", 32'h9);
    wb_wr(STATUS, 32'h8);
    phi_p = 1'b1;
    repeat (4) tick();

    // Abort after pixel 1.
    line_start();
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back({8'd0, 12'(i), 12'h300 + 12'(i)});
      do_pixel(12'h300 + 12'(i), 0, 1'b0);
    end
    phi_p = 1'b1;
    repeat (4) tick();
    wb_rd(STATUS, "abort_status", 32'h212);
    wb_rd(PIXCNT, "pixcnt_abort", 32'd2);
    phi_r = 1'b0;
    nstart = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (adc_start) nstart++;
    end
    check("abort_idle_no_start", nstart, 0);
    phi_r = 1'b1;
    repeat (4) tick();
    sb_read("abort_kept0");
    sb_read("abort_kept1");
    wb_wr(STATUS, 32'h10);
    wb_rd(STATUS, "abort_clear", 32'h1);
    line_start();
    sb_q.push_back({8'd0, 12'd0, 12'h310});
    do_pixel(12'h310, 0, 1'b0);
    sb_read("restart_idx0");
    wb_rd(PIXCNT, "pixcnt_restart", 32'd1);

    // Disable mid-line, then simultaneous pop/push and flush/push.
    wb_wr(CTRL, 32'h2);
    wb_wr(CTRL, 32'h3);
    phi_p = 1'b1;
    repeat (4) tick();
    line_start();
    sb_q.push_back({8'd0, 12'd0, 12'h400});
    do_pixel(12'h400, 0, 1'b0);
    wb_rd(STATUS, "level_one", 32'h100);
    sb_q.push_back({8'd0, 12'd1, 12'h401});
    do_pixel(12'h401, 1, 1'b0);
    wb_rd(STATUS, "pop_push_level", 32'h100);
    do_pixel(12'h402, 2, 1'b0);
    sb_q.delete();
    wb_rd(STATUS, "flush_push_level", 32'h1);
    wb_rd(PIXCNT, "pixcnt_after_flush", 32'd3);
    sb_q.push_back({8'd0, 12'd3, 12'h403});
    do_pixel(12'h403, 0, 1'b0);
    sb_read("after_flush_px3");
    wb_rd(STATUS, "line2_done", 32'h9);

    // Reset in the middle of a line discards everything.
    wb_wr(STATUS, 32'h8);
    phi_p = 1'b1;
    repeat (4) tick();
    line_start();
    do_pixel(12'h500, 0, 1'b0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    wb_rd(CTRL, "midreset_ctrl", 32'h0);
    wb_rd(STATUS, "midreset_status", 32'h1);
    wb_rd(PIXCNT, "midreset_pixcnt", 32'h0);

`ifdef READOUT_ADC_TIMEOUT_EN
    wb_wr(CTRL, 32'h1);
    phi_p = 1'b1;
    repeat (4) tick();
    line_start();
    phi_r = 1'b0;
    nstart = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (adc_start) nstart++;
    end
    phi_r = 1'b1;
    check("timeout_start_once", nstart, 1);
    wb_rd(STATUS, "timeout_status", 32'h21);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccd_readout_sequencer.md
# ccd_readout_sequencer

- Downstream stage of the CCD clock-waveform generator; consumes its `phi_p` and `phi_r` pad-level outputs.
- Per line, detects each pixel's reset-gate release and waits a settle time; then handshakes one conversion with the external ADC.
- Tags each sample with its pixel index, buffers it in a FIFO and exposes it to the Caravel management core over Wishbone.
- Runs entirely on the Wishbone clock.

## Interface
Parameters:
- `BASE_ADDRESS`, 32'h3000_0020: register window base; four word registers at +0x0..+0xC.
- `PIXELS_PER_LINE`, 2052: pixel samples per line.
- `SETTLE_CYCLES`, 4: wb_clk cycles between the detected phi_r fall and the ADC start; legal range 1..255.
- `FIFO_DEPTH`, 16: sample entries; power of two, 2..128.
- `ADC_WIDTH`, 12: ADC result width; legal range 1..12.
- `ADC_TIMEOUT`, 255: CONVERT watchdog limit in cycles; used only with the macro.

Ports:
- `wb_clk_i` in 1: only clock.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1: Wishbone slave controls.
- `wbs_sel_i` in 4: byte selects; ignored, all accesses are full-word.
- `wbs_adr_i`, `wbs_dat_i` in 32: Wishbone address and write data.
- `wbs_ack_o` out 1: Wishbone acknowledge.
- `wbs_dat_o` out 32: Wishbone read data.
- `phi_p_i`, `phi_r_i` in 1: generator outputs, asynchronous to wb_clk_i.
- `adc_start_o` out 1: conversion request, one-cycle pulse.
- `adc_done_i` in 1: conversion complete, synchronous, one-cycle pulse.
- `adc_data_i` in ADC_WIDTH: result, valid while adc_done_i is high.
- `irq_o` out 1: level interrupt.

## Operation
- **Synchronisers:** phi_p_i and phi_r_i each pass through two flops plus a history flop for edge detection.
- **Register map:**
  - CTRL +0x0, R/W: bit0 enable, bit1 irq_en; bit2 flush, write-1 self-clearing, reads 0.
  - STATUS +0x4: bit0 empty; bit1 full; bit2 overflow, W1C; bit3 line_done, W1C; bit4 abort, W1C; bit5 timeout, W1C; [15:8] FIFO level; other bits 0.
  - DATA +0x8, read pops: [11:0] sample zero-extended; [23:12] pixel index 0..PIXELS_PER_LINE-1; [31:24] 0. Reading DATA when empty returns 0 and does not pop.
  - PIXCNT +0xC, RO: pixels converted in the current line, [11:0].
- **FSM states:**
  - IDLE: waits for a phi_p falling edge while enable=1; clears the pixel counter and goes to WAIT_PIX.
  - WAIT_PIX: waits for a phi_r falling edge, then goes to SETTLE.
  - SETTLE: counts SETTLE_CYCLES cycles, then goes to CONVERT.
  - CONVERT: adc_start_o is high in the first cycle only; waits for adc_done_i, latches adc_data_i, then goes to STORE.
  - STORE: pushes {index, sample} and increments the pixel counter. If the counter reaches PIXELS_PER_LINE, sets line_done and goes to IDLE; otherwise goes to WAIT_PIX.
- **Abort:** a phi_p rising edge in any non-IDLE state sets abort and returns to IDLE; a STORE in the same cycle completes first.
- **Disable:** enable=0 forces IDLE next cycle; FIFO contents are kept.
- **Full:** a push while full drops the sample, sets overflow and still increments the pixel counter.
- **Simultaneous push and pop:** both occur and the level is unchanged.
- **Flush:** empties the FIFO; a flush in the same cycle as a push wins, so that sample is discarded and overflow is not set.
- **Interrupt:** irq_o = irq_en & (line_done | overflow | abort | timeout | ~empty).

## Timing
- **Reset:** all outputs and registers are 0, FSM is IDLE, FIFO is empty. Mid-line reset discards everything.
- **phi_r fall to ADC start:** the edge is detected at the 3rd wb_clk rising edge after the pin change (cycle N). SETTLE runs from N+1 to N+SETTLE_CYCLES. adc_start_o is high during cycle N+SETTLE_CYCLES+1.
- **Data to FIFO:** adc_done_i sampled at cycle M causes the push at M+1; the entry is readable at M+2.
- **Wishbone:**
  - wbs_ack_o goes high the cycle after stb&cyc with an address inside the window, for exactly one cycle; it is low for at least one cycle between acks.
  - Outside the window there is no ack.
  - wbs_dat_o is valid with ack; the pop occurs on the ack cycle.

## Configuration
- `READOUT_ADC_TIMEOUT_EN` defined:
  - CONVERT counts cycles; reaching ADC_TIMEOUT without adc_done_i sets timeout, pushes nothing and returns to IDLE.
  - An 8-bit watchdog counter is instantiated.
- Undefined: CONVERT waits indefinitely, the STATUS bit5 timeout flag reads 0, and no watchdog counter exists.

## Test plan
- **Full line:** PIXELS_PER_LINE=4, SETTLE_CYCLES=4. phi_p falls, then 4 phi_r falls; the ADC model answers 3 cycles after start with 0x100+i. Expect FIFO entries {0,0x100}..{3,0x103}, line_done=1 and irq_o=1 when irq_en=1.
- **Latency:** a phi_r fall at cycle 0 gives adc_start_o high in cycle 3+4+1=8 only.
- **Overflow:** FIFO_DEPTH=2, 4 pixels, no reads. Expect level=2, overflow=1 and the first two samples kept; W1C on bit2 clears it.
- **Abort:** phi_p rises after pixel 1. Expect abort=1, FSM in IDLE, PIXCNT=2, 2 entries; the next line restarts at index 0.
- **Wishbone edges:**
  - DATA read on empty returns 0 with level unchanged.
  - Simultaneous pop and push leaves level unchanged.
  - Flush plus push in the same cycle gives level=0.
  - Address BASE+0x10 gives no ack.
- **Timeout (macro on):** ADC_TIMEOUT=20 with adc_done_i held low. Expect timeout=1 and IDLE after 20 cycles in CONVERT; no push.
